// File: rtl/except_flush_ctrl.sv
// except_flush_ctrl: exception entry / ERET return sequencer.
// Captures a writeback exception or ERET, pulses the CP0 update for one cycle,
// holds the pipeline flush for FLUSH_CYCLES cycles, then offers a fetch
// redirect (handler, EPC or boot vector) over a valid/ready handshake.
// Optional build macro EXC_CNT_EN adds a 32-bit count of exceptions taken.
//
// state      | meaning
// S_BOOT     | after reset, offering BOOT_VECTOR to fetch, flush held
// S_IDLE     | normal execution, watching writeback for exception/ERET
// S_FLUSH    | flush held; CP0 pulse on first cycle; counting down
// S_REDIRECT | flush held, redirect offered until fetch accepts
module except_flush_ctrl #(
  parameter logic [31:0] BOOT_VECTOR  = 32'hbfc00000,
  parameter logic [31:0] EXC_VECTOR   = 32'hbfc00380,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        wb_valid,
  input  logic [5:0]  wb_ex,
  input  logic        wb_eret,
  input  logic [31:0] wb_pc,
  input  logic        wb_bd,
  input  logic [31:0] wb_badvaddr,
  input  logic [31:0] cp0_epc,
  input  logic        cp0_exl,
  output logic        flush,
  output logic        busy,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  input  logic        redirect_ready,
  output logic        cp0_cause_we,
  output logic        cp0_epc_we,
  output logic        cp0_badv_we,
  output logic        cp0_exl_clr,
  output logic [4:0]  cp0_exccode,
  output logic        cp0_bd,
  output logic [31:0] cp0_epc_wdata,
  output logic [31:0] cp0_badv_wdata,
  output logic [31:0] exc_count
);

  typedef enum logic [1:0] {S_BOOT, S_IDLE, S_FLUSH, S_REDIRECT} state_t;

  localparam logic [3:0] LP_CNT_INIT = 4'(FLUSH_CYCLES - 1);
  localparam logic [4:0] LP_CODE_ADEL = 5'h04;

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_cnt;
  logic [31:0] r_target;
  logic [4:0]  r_code;
  logic [31:0] r_epc_wdata;
  logic [31:0] r_badv;
  logic        r_bd;
  logic        r_is_exc;
  logic        r_exl;

  logic        w_event;
  logic        w_is_exc;
  logic        w_take;
  logic        w_first;
  logic [4:0]  w_code;

  // Lowest flag bit wins when several exceptions are raised together.
  function automatic logic [4:0] exc_code(input logic [5:0] ex);
    logic [4:0] c;
    c = 5'h00;
    if      (ex[0]) c = 5'h00;
    else if (ex[1]) c = 5'h04;
    else if (ex[2]) c = 5'h0a;
    else if (ex[3]) c = 5'h0c;
    else if (ex[4]) c = 5'h08;
    else if (ex[5]) c = 5'h09;
    return c;
  endfunction

  assign w_event  = wb_valid & ((|wb_ex) | wb_eret);
  assign w_is_exc = |wb_ex;
  assign w_code   = exc_code(wb_ex);
  assign w_take   = (r_state == S_IDLE) & w_event;
  // The counter only holds its load value during the first FLUSH cycle.
  assign w_first  = (r_state == S_FLUSH) & (r_cnt == LP_CNT_INIT);

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_BOOT;
    else       r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_BOOT:     if (redirect_ready) w_next = S_IDLE;
      S_IDLE:     if (w_event) w_next = S_FLUSH;
      S_FLUSH:    if (r_cnt == 4'd0) w_next = S_REDIRECT;
      S_REDIRECT: if (redirect_ready) w_next = S_IDLE;
      default:    w_next = S_BOOT;
    endcase
  end

  // Flush hold counter: load on entry, count down while flushing.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                                r_cnt <= 4'd0;
    else if (w_take)                          r_cnt <= LP_CNT_INIT;
    else if (r_state == S_FLUSH && r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
  end

  // Capture the event details on the entry edge; exception beats ERET.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_target    <= BOOT_VECTOR;
      r_code      <= 5'h00;
      r_epc_wdata <= 32'h0;
      r_badv      <= 32'h0;
      r_bd        <= 1'b0;
      r_is_exc    <= 1'b0;
      r_exl       <= 1'b0;
    end else if (w_take) begin
      r_target    <= w_is_exc ? EXC_VECTOR : cp0_epc;
      r_code      <= w_code;
      r_epc_wdata <= wb_bd ? (wb_pc - 32'd4) : wb_pc;
      r_badv      <= wb_badvaddr;
      r_bd        <= wb_bd;
      r_is_exc    <= w_is_exc;
      r_exl       <= cp0_exl;
    end
  end

  // Control outputs; everything is forced low while reset is held.
  always_comb begin
    flush          = 1'b0;
    busy           = 1'b0;
    redirect_valid = 1'b0;
    cp0_cause_we   = 1'b0;
    cp0_epc_we     = 1'b0;
    cp0_badv_we    = 1'b0;
    cp0_exl_clr    = 1'b0;
    if (!reset) begin
      busy = (r_state != S_IDLE);
      case (r_state)
        S_BOOT: begin
          flush          = 1'b1;
          redirect_valid = 1'b1;
        end
        S_FLUSH: begin
          flush        = 1'b1;
          cp0_cause_we = w_first & r_is_exc;
          cp0_epc_we   = w_first & r_is_exc & ~r_exl;
          cp0_badv_we  = w_first & r_is_exc & (r_code == LP_CODE_ADEL);
          cp0_exl_clr  = w_first & ~r_is_exc;
        end
        S_REDIRECT: begin
          flush          = 1'b1;
          redirect_valid = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign redirect_pc    = (r_state == S_BOOT) ? BOOT_VECTOR : r_target;
  assign cp0_exccode    = r_code;
  assign cp0_bd         = r_bd;
  assign cp0_epc_wdata  = r_epc_wdata;
  assign cp0_badv_wdata = r_badv;

`ifdef EXC_CNT_EN
  logic [31:0] r_exc_cnt;

  // Count exception entries (ERET excluded); wraps naturally.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                r_exc_cnt <= 32'h0;
    else if (w_take & w_is_exc) r_exc_cnt <= r_exc_cnt + 32'd1;
  end

  assign exc_count = r_exc_cnt;
`else
  assign exc_count = 32'h0;
`endif

endmodule

// File: tb/tb_except_flush_ctrl.sv
// Bench for except_flush_ctrl: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a transaction model.
module tb_except_flush_ctrl;

  localparam logic [31:0] BOOT = 32'hbfc00000;
  localparam logic [31:0] EXCV = 32'hbfc00380;
  localparam int F = 2;

  logic        clock = 1'b0;
  logic        reset;
  logic        wb_valid, wb_eret, wb_bd, cp0_exl, redirect_ready;
  logic [5:0]  wb_ex;
  logic [31:0] wb_pc, wb_badvaddr, cp0_epc;
  logic        flush, busy, redirect_valid;
  logic [31:0] redirect_pc;
  logic        cp0_cause_we, cp0_epc_we, cp0_badv_we, cp0_exl_clr, cp0_bd;
  logic [4:0]  cp0_exccode;
  logic [31:0] cp0_epc_wdata, cp0_badv_wdata, exc_count;

  int n_cmp = 0;
  int n_bad = 0;

  except_flush_ctrl #(.BOOT_VECTOR(BOOT), .EXC_VECTOR(EXCV), .FLUSH_CYCLES(F)) dut (
    .clock(clock), .reset(reset), .wb_valid(wb_valid), .wb_ex(wb_ex), .wb_eret(wb_eret),
    .wb_pc(wb_pc), .wb_bd(wb_bd), .wb_badvaddr(wb_badvaddr), .cp0_epc(cp0_epc),
    .cp0_exl(cp0_exl), .flush(flush), .busy(busy), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .redirect_ready(redirect_ready),
    .cp0_cause_we(cp0_cause_we), .cp0_epc_we(cp0_epc_we), .cp0_badv_we(cp0_badv_we),
    .cp0_exl_clr(cp0_exl_clr), .cp0_exccode(cp0_exccode), .cp0_bd(cp0_bd),
    .cp0_epc_wdata(cp0_epc_wdata), .cp0_badv_wdata(cp0_badv_wdata), .exc_count(exc_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  bit          m_boot = 1'b1;
  bit          m_active = 1'b0;
  int          m_age = 0;        // cycles since exception/ERET entry (1 = first)
  bit          t_exc, t_bd, t_exl;
  logic [4:0]  t_code;
  logic [31:0] t_target, t_epc, t_badv;
  logic [31:0] m_cnt = 32'h0;

  function automatic logic [4:0] model_code(input logic [5:0] ex);
    logic [4:0] tbl [6];
    tbl = '{5'h00, 5'h04, 5'h0a, 5'h0c, 5'h08, 5'h09};
    for (int i = 0; i < 6; i++) if (ex[i]) return tbl[i];
    return 5'h00;
  endfunction

  // Compare every cycle, then advance the model across the coming edge.
  always @(negedge clock) begin
    bit e_flush, e_busy, e_valid, first;
    logic [31:0] e_cnt;
`ifdef EXC_CNT_EN
    e_cnt = m_cnt;
`else
    e_cnt = 32'h0;
`endif
    if (reset) begin
      chk("rst_flush", 32'(flush), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_valid", 32'(redirect_valid), 0);
      chk("rst_pc", redirect_pc, BOOT);
      chk("rst_we", {28'h0, cp0_cause_we, cp0_epc_we, cp0_badv_we, cp0_exl_clr}, 0);
      chk("rst_data", {26'h0, cp0_bd, cp0_exccode} | cp0_epc_wdata | cp0_badv_wdata, 0);
      chk("rst_cnt", exc_count, 0);
      m_boot = 1'b1; m_active = 1'b0; m_cnt = 32'h0;
    end else begin
      first   = m_active && m_age == 1;
      e_flush = m_boot || m_active;
      e_busy  = e_flush;
      e_valid = m_boot || (m_active && m_age > F);
      chk("flush", 32'(flush), 32'(e_flush));
      chk("busy", 32'(busy), 32'(e_busy));
      chk("redirect_valid", 32'(redirect_valid), 32'(e_valid));
      if (e_valid) chk("redirect_pc", redirect_pc, m_boot ? BOOT : t_target);
      chk("cause_we", 32'(cp0_cause_we), 32'(first && t_exc));
      chk("epc_we", 32'(cp0_epc_we), 32'(first && t_exc && !t_exl));
      chk("badv_we", 32'(cp0_badv_we), 32'(first && t_exc && t_code == 5'h04));
      chk("exl_clr", 32'(cp0_exl_clr), 32'(first && !t_exc));
      if (first && t_exc) begin
        chk("exccode", 32'(cp0_exccode), 32'(t_code));
        chk("bd", 32'(cp0_bd), 32'(t_bd));
        chk("epc_wdata", cp0_epc_wdata, t_epc);
        if (t_code == 5'h04) chk("badv_wdata", cp0_badv_wdata, t_badv);
      end
      chk("exc_count", exc_count, e_cnt);
      if (m_boot) begin
        if (redirect_ready) m_boot = 1'b0;
      end else if (!m_active) begin
        if (wb_valid && (wb_ex != 0 || wb_eret)) begin
          m_active = 1'b1; m_age = 1;
          t_exc    = (wb_ex != 0);
          t_code   = model_code(wb_ex);
          t_target = t_exc ? EXCV : cp0_epc;
          t_epc    = wb_bd ? wb_pc - 32'd4 : wb_pc;
          t_bd     = wb_bd; t_exl = cp0_exl; t_badv = wb_badvaddr;
          if (t_exc) m_cnt = m_cnt + 1;
        end
      end else if (m_age > F && redirect_ready) begin
        m_active = 1'b0;
      end else begin
        m_age++;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic ev(input logic [5:0] ex, input logic eret, input logic [31:0] pc,
                    input logic bd, input logic [31:0] badv, input logic [31:0] epc,
                    input logic exl);
    wb_valid = 1'b1; wb_ex = ex; wb_eret = eret; wb_pc = pc; wb_bd = bd;
    wb_badvaddr = badv; cp0_epc = epc; cp0_exl = exl;
    tick();
    wb_valid = 1'b0; wb_ex = 6'h0; wb_eret = 1'b0;
  endtask

  task automatic wait_state(input bit want_valid, input string nm);
    int k;
    k = 0;
    @(negedge clock);
    while ((want_valid ? redirect_valid : busy) !== want_valid && k < 50) begin
      tick(); @(negedge clock); k++;
    end
    if (k >= 50) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: timeout after %0d cycles", nm, k);
    end
  endtask

  logic [31:0] exp_cnt;

  initial begin
    reset = 1'b1; wb_valid = 0; wb_ex = 0; wb_eret = 0; wb_pc = 0; wb_bd = 0;
    wb_badvaddr = 0; cp0_epc = 0; cp0_exl = 0; redirect_ready = 0;
    repeat (2) tick();
    reset = 1'b0;
    // Boot handshake: ready on the third cycle after release.
    @(negedge clock); chk("lit_boot_valid", 32'(redirect_valid), 1);
    chk("lit_boot_pc", redirect_pc, 32'hbfc00000); chk("lit_boot_flush", 32'(flush), 1);
    tick(); @(negedge clock); chk("lit_boot_valid2", 32'(redirect_valid), 1);
    tick(); redirect_ready = 1'b1;
    @(negedge clock); chk("lit_boot_busy3", 32'(busy), 1);
    tick(); @(negedge clock); chk("lit_idle_busy", 32'(busy), 0);
    chk("lit_idle_flush", 32'(flush), 0);

    // RI, not in delay slot, EXL clear.
    ev(6'b000100, 0, 32'h80001000, 0, 32'h0, 32'h0, 0);
    @(negedge clock);
    chk("lit_ri_cause_we", 32'(cp0_cause_we), 1); chk("lit_ri_epc_we", 32'(cp0_epc_we), 1);
    chk("lit_ri_code", 32'(cp0_exccode), 32'h0a); chk("lit_ri_epc", cp0_epc_wdata, 32'h80001000);
    tick(); @(negedge clock);
    chk("lit_ri_flush2", 32'(flush), 1); chk("lit_ri_novalid", 32'(redirect_valid), 0);
    chk("lit_ri_pulse_once", 32'(cp0_cause_we), 0);
    tick(); @(negedge clock);
    chk("lit_ri_valid", 32'(redirect_valid), 1); chk("lit_ri_pc", redirect_pc, 32'hbfc00380);
    tick(); @(negedge clock); chk("lit_ri_idle", 32'(busy), 0);

    // AdEL in a delay slot.
    ev(6'b000010, 0, 32'h80002004, 1, 32'h80002001, 32'h0, 0);
    @(negedge clock);
    chk("lit_adel_epc", cp0_epc_wdata, 32'h80002000); chk("lit_adel_bd", 32'(cp0_bd), 1);
    chk("lit_adel_badv_we", 32'(cp0_badv_we), 1); chk("lit_adel_code", 32'(cp0_exccode), 32'h04);
    chk("lit_adel_badv", cp0_badv_wdata, 32'h80002001);
    tick(); wait_state(1'b0, "adel_idle");

    // Nested exception with EXL already set.
    tick();
    ev(6'b001000, 0, 32'h80004000, 0, 32'h0, 32'h0, 1);
    @(negedge clock);
    chk("lit_exl_cause_we", 32'(cp0_cause_we), 1); chk("lit_exl_epc_we", 32'(cp0_epc_we), 0);
    tick(); wait_state(1'b1, "exl_valid");
    chk("lit_exl_pc", redirect_pc, 32'hbfc00380);
    tick(); wait_state(1'b0, "exl_idle");

    // ERET with fetch stalling for 5 cycles.
    redirect_ready = 1'b0;
    tick();
    ev(6'b000000, 1, 32'h80005000, 0, 32'h0, 32'h80003000, 1);
    @(negedge clock);
    chk("lit_eret_clr", 32'(cp0_exl_clr), 1); chk("lit_eret_nocause", 32'(cp0_cause_we), 0);
    tick(); @(negedge clock); chk("lit_eret_clr_once", 32'(cp0_exl_clr), 0);
    tick(); wait_state(1'b1, "eret_valid");
    for (int i = 0; i < 5; i++) begin
      if (i > 0) begin tick(); @(negedge clock); end
      chk("lit_eret_stall_valid", 32'(redirect_valid), 1);
      chk("lit_eret_stall_pc", redirect_pc, 32'h80003000);
    end
    tick(); redirect_ready = 1'b1;
    tick(); @(negedge clock); chk("lit_eret_idle", 32'(busy), 0);

    // Exception and ERET together: exception wins with Int.
    tick();
    ev(6'b001001, 1, 32'h80006000, 0, 32'h0, 32'h80003000, 0);
    @(negedge clock);
    chk("lit_both_code", 32'(cp0_exccode), 32'h00); chk("lit_both_cause", 32'(cp0_cause_we), 1);
    chk("lit_both_noclr", 32'(cp0_exl_clr), 0);
`ifdef EXC_CNT_EN
    exp_cnt = 32'd4;
`else
    exp_cnt = 32'd0;
`endif
    chk("lit_both_count", exc_count, exp_cnt);
    tick(); wait_state(1'b0, "both_idle");

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      tick();
      reset          = ($urandom_range(0, 399) == 0);
      wb_valid       = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 3))
        0:       wb_ex = 6'h0;
        1:       wb_ex = 6'($urandom);
        default: wb_ex = 6'(6'b1 << $urandom_range(0, 5));
      endcase
      wb_eret        = ($urandom_range(0, 2) == 0);
      wb_pc          = {$urandom} & 32'hfffffffc;
      wb_bd          = 1'($urandom);
      wb_badvaddr    = $urandom;
      cp0_epc        = {$urandom} & 32'hfffffffc;
      cp0_exl        = 1'($urandom);
      redirect_ready = ($urandom_range(0, 1) == 0);
    end
    tick(); reset = 1'b0;
    repeat (3) tick();
    @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
